// File: rtl/sw_cell_pipe.sv
// sw_cell_pipe: two-stage Smith-Waterman cell with valid/ready handshakes.
// Stage 1 applies gap/match/mismatch scoring. Stage 2 picks the winning score
// and the traceback arrow. Tile number and offset travel with the data.
// Optional macro SW_BEST_TRACK_EN adds a per-tile best-score tracker.
// Without that macro, the best_* outputs are tied to zero and `last` is ignored.
module sw_cell_pipe #(
    parameter int unsigned SCORE_W  = 8,
    parameter int unsigned SYM_W    = 2,
    parameter int unsigned TILE_W   = 4,
    parameter int unsigned OFF_W    = 8,
    parameter int unsigned MATCH    = 2,
    parameter int unsigned MISMATCH = 1,
    parameter int unsigned GAP      = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [SYM_W-1:0]   letter1,
    input  logic [SYM_W-1:0]   letter2,
    input  logic [SCORE_W-1:0] up_val,
    input  logic [SCORE_W-1:0] left_val,
    input  logic [SCORE_W-1:0] diagonal_val,
    input  logic [TILE_W-1:0]  tileNum,
    input  logic [OFF_W-1:0]   offset,
    input  logic               last,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [SCORE_W-1:0] val,
    output logic [1:0]         arrow,
    output logic [TILE_W-1:0]  tileNumOut,
    output logic [OFF_W-1:0]   offsetOut,
    output logic               best_valid,
    output logic [SCORE_W-1:0] best_val,
    output logic [OFF_W-1:0]   best_offset,
    output logic [TILE_W-1:0]  best_tile
);

    localparam int unsigned EXT_W = SCORE_W + 1;
    localparam logic [EXT_W-1:0] GAP_X   = EXT_W'(GAP);
    localparam logic [EXT_W-1:0] MATCH_X = EXT_W'(MATCH);
    localparam logic [EXT_W-1:0] MISM_X  = EXT_W'(MISMATCH);
    localparam logic [EXT_W-1:0] SAT_MAX = {1'b0, {SCORE_W{1'b1}}};

    localparam logic [1:0] ARROW_NONE = 2'b00;
    localparam logic [1:0] ARROW_UP   = 2'b01;
    localparam logic [1:0] ARROW_LEFT = 2'b10;
    localparam logic [1:0] ARROW_DIAG = 2'b11;

    // Stage 1 registers
    logic               s1_valid_q;
    logic [SCORE_W-1:0] s1_up_q, s1_left_q, s1_diag_q;
    logic [TILE_W-1:0]  s1_tile_q;
    logic [OFF_W-1:0]   s1_off_q;

    // Stage 2 (output) registers
    logic               out_valid_q;
    logic [SCORE_W-1:0] val_q;
    logic [1:0]         arrow_q;
    logic [TILE_W-1:0]  tile_q;
    logic [OFF_W-1:0]   off_q;

    // Combinational stage results
    logic [EXT_W-1:0]   up_x, left_x, diag_x, diag_sum;
    logic [SCORE_W-1:0] r_up_c, r_left_c, r_diag_c;
    logic [SCORE_W-1:0] val_d;
    logic [1:0]         arrow_d;
    logic               s1_adv, s2_adv;

    // Stage advance: a stage moves when its successor is empty or moving
    assign s2_adv   = !out_valid_q || out_ready;
    assign s1_adv   = !s1_valid_q || s2_adv;
    assign in_ready = s1_adv;

    // Stage 1 penalties in SCORE_W+1 bits, saturating at 0 and at full scale
    always_comb begin
        up_x     = {1'b0, up_val};
        left_x   = {1'b0, left_val};
        diag_x   = {1'b0, diagonal_val};
        diag_sum = diag_x + MATCH_X;
        r_up_c   = (up_x > GAP_X) ? SCORE_W'(up_x - GAP_X) : '0;
        r_left_c = (left_x > GAP_X) ? SCORE_W'(left_x - GAP_X) : '0;
        if (letter1 == letter2) begin
            r_diag_c = (diag_sum > SAT_MAX) ? SAT_MAX[SCORE_W-1:0] : SCORE_W'(diag_sum);
        end else begin
            r_diag_c = (diag_x > MISM_X) ? SCORE_W'(diag_x - MISM_X) : '0;
        end
    end

    // Stage 2 select: diag wins ties, then left, then up; all-zero gives no arrow
    always_comb begin
        val_d   = '0;
        arrow_d = ARROW_NONE;
        if ((s1_diag_q == '0) && (s1_up_q == '0) && (s1_left_q == '0)) begin
            val_d   = '0;
            arrow_d = ARROW_NONE;
        end else if ((s1_diag_q >= s1_up_q) && (s1_diag_q >= s1_left_q)) begin
            val_d   = s1_diag_q;
            arrow_d = ARROW_DIAG;
        end else if (s1_left_q >= s1_up_q) begin
            val_d   = s1_left_q;
            arrow_d = ARROW_LEFT;
        end else begin
            val_d   = s1_up_q;
            arrow_d = ARROW_UP;
        end
    end

    // Pipeline registers: data and sideband advance together; stalled stages hold
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_q  <= 1'b0;
            s1_up_q     <= '0;
            s1_left_q   <= '0;
            s1_diag_q   <= '0;
            s1_tile_q   <= '0;
            s1_off_q    <= '0;
            out_valid_q <= 1'b0;
            val_q       <= '0;
            arrow_q     <= ARROW_NONE;
            tile_q      <= '0;
            off_q       <= '0;
        end else begin
            if (s1_adv) begin
                s1_valid_q <= in_valid;
                if (in_valid) begin
                    s1_up_q   <= r_up_c;
                    s1_left_q <= r_left_c;
                    s1_diag_q <= r_diag_c;
                    s1_tile_q <= tileNum;
                    s1_off_q  <= offset;
                end
            end
            if (s2_adv) begin
                out_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    val_q   <= val_d;
                    arrow_q <= arrow_d;
                    tile_q  <= s1_tile_q;
                    off_q   <= s1_off_q;
                end
            end
        end
    end

    assign out_valid  = out_valid_q;
    assign val        = val_q;
    assign arrow      = arrow_q;
    assign tileNumOut = tile_q;
    assign offsetOut  = off_q;

`ifdef SW_BEST_TRACK_EN
    logic               s1_last_q, last_q;
    logic               best_valid_q;
    logic [SCORE_W-1:0] best_val_q, run_val_q, fold_val_c;
    logic [OFF_W-1:0]   best_off_q, run_off_q, fold_off_c;
    logic [TILE_W-1:0]  best_tile_q, run_tile_q, fold_tile_c;
    logic               out_hs_c;

    assign out_hs_c = out_valid_q && out_ready;

    // Fold the current output into the running best; the first occurrence of a tie wins
    always_comb begin
        fold_val_c  = run_val_q;
        fold_off_c  = run_off_q;
        fold_tile_c = run_tile_q;
        if (val_q > run_val_q) begin
            fold_val_c  = val_q;
            fold_off_c  = off_q;
            fold_tile_c = tile_q;
        end
    end

    // The last flag travels with the beat through both stages
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_last_q <= 1'b0;
            last_q    <= 1'b0;
        end else begin
            if (s1_adv && in_valid) begin
                s1_last_q <= last;
            end
            if (s2_adv && s1_valid_q) begin
                last_q <= s1_last_q;
            end
        end
    end

    // Tracker: update on output handshake; a last beat publishes the best and restarts from 0
    always_ff @(posedge clk) begin
        if (reset) begin
            best_valid_q <= 1'b0;
            best_val_q   <= '0;
            best_off_q   <= '0;
            best_tile_q  <= '0;
            run_val_q    <= '0;
            run_off_q    <= '0;
            run_tile_q   <= '0;
        end else begin
            best_valid_q <= 1'b0;
            if (out_hs_c) begin
                if (last_q) begin
                    best_valid_q <= 1'b1;
                    best_val_q   <= fold_val_c;
                    best_off_q   <= fold_off_c;
                    best_tile_q  <= fold_tile_c;
                    run_val_q    <= '0;
                    run_off_q    <= '0;
                    run_tile_q   <= '0;
                end else begin
                    run_val_q  <= fold_val_c;
                    run_off_q  <= fold_off_c;
                    run_tile_q <= fold_tile_c;
                end
            end
        end
    end

    assign best_valid  = best_valid_q;
    assign best_val    = best_val_q;
    assign best_offset = best_off_q;
    assign best_tile   = best_tile_q;
`else
    logic unused_last;
    assign unused_last = last;

    assign best_valid  = 1'b0;
    assign best_val    = '0;
    assign best_offset = '0;
    assign best_tile   = '0;
`endif

endmodule

// File: tb/tb_sw_cell_pipe.sv
// Testbench for sw_cell_pipe. It runs directed scenarios and a randomized run.
// All of them are checked against a behavioural scoreboard.
module tb_sw_cell_pipe;

    localparam int MAXV    = 255;
    localparam int MATCH_V = 2;
    localparam int MISM_V  = 1;
    localparam int GAP_V   = 1;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid, in_ready;
    logic [1:0] letter1, letter2;
    logic [7:0] up_val, left_val, diagonal_val;
    logic [3:0] tileNum;
    logic [7:0] offset;
    logic       last;
    logic       out_valid, out_ready;
    logic [7:0] val;
    logic [1:0] arrow;
    logic [3:0] tileNumOut;
    logic [7:0] offsetOut;
    logic       best_valid;
    logic [7:0] best_val, best_offset;
    logic [3:0] best_tile;

    always #5 clk = ~clk;

    sw_cell_pipe dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .letter1(letter1), .letter2(letter2),
        .up_val(up_val), .left_val(left_val), .diagonal_val(diagonal_val),
        .tileNum(tileNum), .offset(offset), .last(last),
        .out_valid(out_valid), .out_ready(out_ready),
        .val(val), .arrow(arrow), .tileNumOut(tileNumOut), .offsetOut(offsetOut),
        .best_valid(best_valid), .best_val(best_val),
        .best_offset(best_offset), .best_tile(best_tile)
    );

    typedef struct {
        int v;
        int a;
        int tile;
        int off;
        bit lst;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    int   run_v = 0, run_o = 0, run_t = 0;
    int   eb_valid = 0, eb_val = 0, eb_off = 0, eb_tile = 0;
    bit   last_in_hs = 1'b0;
    bit   smp_in_ready = 1'b1;
    int   outs_seen = 0;

    task automatic chk(input int obs, input int exp, input string tag);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference cell: scores computed with plain integer arithmetic
    function automatic exp_t model(input int l1, input int l2, input int up, input int lf,
                                   input int dg, input int tile, input int off, input bit lst);
        exp_t e;
        int ru, rl, rd, m;
        ru = (up > GAP_V) ? up - GAP_V : 0;
        rl = (lf > GAP_V) ? lf - GAP_V : 0;
        if (l1 == l2) rd = (dg + MATCH_V > MAXV) ? MAXV : dg + MATCH_V;
        else          rd = (dg > MISM_V) ? dg - MISM_V : 0;
        m = ru;
        if (rl > m) m = rl;
        if (rd > m) m = rd;
        e.v = m;
        if (m == 0)       e.a = 0;
        else if (rd == m) e.a = 3;
        else if (rl == m) e.a = 2;
        else              e.a = 1;
        e.tile = tile;
        e.off  = off;
        e.lst  = lst;
        return e;
    endfunction

    // One clock: check visible output against the scoreboard, clock, update models, check best_*
    task automatic cycle();
        bit   in_hs, out_hs;
        exp_t e, e_in;
        #1;
        smp_in_ready = in_ready;
        in_hs  = in_valid && in_ready && !reset;
        out_hs = out_valid && out_ready && !reset;
        if (out_valid) begin
            if (q.size() == 0) begin
                chk(int'(out_valid), 0, "stale_or_extra_out");
            end else begin
                e = q[0];
                chk(int'(val), e.v, "val");
                chk(int'(arrow), e.a, "arrow");
                chk(int'(tileNumOut), e.tile, "tileNumOut");
                chk(int'(offsetOut), e.off, "offsetOut");
            end
        end
        if (in_hs) begin
            e_in = model(int'(letter1), int'(letter2), int'(up_val), int'(left_val),
                         int'(diagonal_val), int'(tileNum), int'(offset), last);
        end
        @(posedge clk);
        eb_valid = 0;
        if (reset) begin
            q.delete();
            run_v = 0; run_o = 0; run_t = 0;
            eb_val = 0; eb_off = 0; eb_tile = 0;
        end else begin
            if (out_hs && q.size() > 0) begin
                e = q.pop_front();
                outs_seen++;
                if (e.v > run_v) begin
                    run_v = e.v; run_o = e.off; run_t = e.tile;
                end
                if (e.lst) begin
                    eb_valid = 1; eb_val = run_v; eb_off = run_o; eb_tile = run_t;
                    run_v = 0; run_o = 0; run_t = 0;
                end
            end
            if (in_hs) q.push_back(e_in);
        end
        last_in_hs = in_hs;
        #1;
`ifdef SW_BEST_TRACK_EN
        chk(int'(best_valid), eb_valid, "best_valid");
        chk(int'(best_val), eb_val, "best_val");
        chk(int'(best_offset), eb_off, "best_offset");
        chk(int'(best_tile), eb_tile, "best_tile");
`else
        chk(int'(best_valid), 0, "best_valid_off");
        chk(int'(best_val), 0, "best_val_off");
        chk(int'(best_offset), 0, "best_offset_off");
        chk(int'(best_tile), 0, "best_tile_off");
`endif
    endtask

    task automatic send(input int l1, input int l2, input int up, input int lf, input int dg,
                        input int tile, input int off, input bit lst);
        in_valid     = 1'b1;
        letter1      = 2'(l1);
        letter2      = 2'(l2);
        up_val       = 8'(up);
        left_val     = 8'(lf);
        diagonal_val = 8'(dg);
        tileNum      = 4'(tile);
        offset       = 8'(off);
        last         = lst;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        last     = 1'b0;
    endtask

    task automatic wait_out(input string tag);
        int n = 0;
        while (!out_valid && n < 10) begin
            cycle();
            n++;
        end
        chk(int'(out_valid), 1, tag);
    endtask

    task automatic wait_best();
        int n = 0;
        while (!best_valid && n < 12) begin
            cycle();
            n++;
        end
    endtask

    initial begin
        int k, acc_at_drop, seen0, tile_r, off_r;

        reset = 1'b1; out_ready = 1'b1;
        send(0, 0, 0, 0, 0, 0, 0, 1'b0);
        idle();
        cycle();
        cycle();
        chk(int'(out_valid), 0, "rst_out_valid");
        chk(int'(val), 0, "rst_val");
        chk(int'(arrow), 0, "rst_arrow");
        chk(int'(in_ready), 1, "rst_in_ready");
        reset = 1'b0;
        cycle();

        // Equal letters, diag 5 / up 3 / left 4: val 7, arrow diag, two cycles after accept
        send(1, 1, 3, 4, 5, 2, 10, 1'b0);
        cycle();
        chk(int'(last_in_hs), 1, "t1_accept");
        idle();
        chk(int'(out_valid), 0, "t1_lat1");
        cycle();
        chk(int'(out_valid), 1, "t1_lat2");
        chk(int'(val), 7, "t1_val");
        chk(int'(arrow), 3, "t1_arrow");
        cycle();

        // All-zero result, then left beats up on a tie
        send(0, 1, 1, 0, 1, 2, 11, 1'b0);
        cycle();
        idle();
        wait_out("t2a_wait");
        chk(int'(val), 0, "t2a_val");
        chk(int'(arrow), 0, "t2a_arrow");
        cycle();
        send(0, 1, 6, 6, 0, 2, 12, 1'b0);
        cycle();
        idle();
        wait_out("t2b_wait");
        chk(int'(val), 5, "t2b_val");
        chk(int'(arrow), 2, "t2b_arrow");
        cycle();

        // Match saturates at full scale
        send(2, 2, 0, 0, 254, 2, 13, 1'b0);
        cycle();
        idle();
        wait_out("t3_wait");
        chk(int'(val), 255, "t3_val");
        chk(int'(arrow), 3, "t3_arrow");
        cycle();

        // Six-beat stream with out_ready low in cycles 2..5
        k = 0; acc_at_drop = -1; seen0 = outs_seen;
        for (int c = 0; c < 40; c++) begin
            out_ready = !(c >= 2 && c <= 5);
            if (k < 6)
                send(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                     int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                     int'($urandom_range(0, 255)), 5, k, 1'b0);
            else
                idle();
            cycle();
            if (!smp_in_ready && acc_at_drop < 0) acc_at_drop = k;
            if (last_in_hs) k++;
        end
        chk(acc_at_drop, 2, "t4_in_ready_drop");
        chk(outs_seen - seen0, 6, "t4_results_out");
        out_ready = 1'b1;

        // Best tracker: scores 4,9,9,2 in tile 3, then a tile whose max is 1
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        send(0, 1, 5, 0, 0, 3, 0, 1'b0);  cycle();
        send(0, 1, 10, 0, 0, 3, 1, 1'b0); cycle();
        send(0, 1, 10, 0, 0, 3, 2, 1'b0); cycle();
        send(0, 1, 3, 0, 0, 3, 3, 1'b1);  cycle();
        idle();
        wait_best();
`ifdef SW_BEST_TRACK_EN
        chk(int'(best_valid), 1, "t5_pulse");
        chk(int'(best_val), 9, "t5_best_val");
        chk(int'(best_offset), 1, "t5_best_off");
        chk(int'(best_tile), 3, "t5_best_tile");
`endif
        cycle();
        send(0, 1, 2, 0, 0, 4, 0, 1'b0); cycle();
        send(0, 1, 0, 0, 0, 4, 1, 1'b1); cycle();
        idle();
        wait_best();
`ifdef SW_BEST_TRACK_EN
        chk(int'(best_val), 1, "t5b_best_val");
        chk(int'(best_offset), 0, "t5b_best_off");
        chk(int'(best_tile), 4, "t5b_best_tile");
`endif
        cycle();

        // Reset with two beats in flight discards them
        send(3, 3, 50, 60, 70, 9, 33, 1'b0); cycle();
        send(1, 2, 80, 20, 10, 9, 34, 1'b1); cycle();
        idle();
        reset = 1'b1;
        cycle();
        chk(int'(out_valid), 0, "t6_out_valid");
        chk(int'(val), 0, "t6_val");
        chk(int'(arrow), 0, "t6_arrow");
        chk(int'(tileNumOut), 0, "t6_tile");
        chk(int'(offsetOut), 0, "t6_off");
        chk(int'(in_ready), 1, "t6_in_ready");
        reset = 1'b0;
        for (int i = 0; i < 5; i++) cycle();
        chk(int'(out_valid), 0, "t6_no_stale");

        // Randomized traffic with random back-pressure and tile boundaries
        tile_r = 0; off_r = 0;
        for (int i = 0; i < 300; i++) begin
            out_ready = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 3) != 0)
                send(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                     int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                     int'($urandom_range(0, 255)), tile_r, off_r,
                     ($urandom_range(0, 4) == 0));
            else
                idle();
            cycle();
            if (last_in_hs) begin
                if (last) begin
                    tile_r = (tile_r + 1) % 16;
                    off_r  = 0;
                end else begin
                    off_r = (off_r + 1) % 256;
                end
            end
        end
        idle();
        out_ready = 1'b1;
        for (int i = 0; i < 20 && q.size() > 0; i++) cycle();
        chk(q.size(), 0, "drain_empty");
        cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/sw_cell_pipe.md
# sw_cell_pipe

Parametrised, pipelined successor to the single-cell Smith-Waterman scoring element in the alignment array. It computes one local-alignment matrix cell per accepted beat from two symbols and the up, left and diagonal neighbour scores, and emits the cell score plus a traceback arrow. Inputs and outputs use valid/ready handshakes, and the pipeline is two stages deep. It also tracks the best score per tile for traceback start-point selection. Tile number and offset travel through the pipeline with the data.

## Interface
- SCORE_W, 8, score width (unsigned)
- SYM_W, 2, symbol width
- TILE_W, 4, tile number width
- OFF_W, 8, offset width
- MATCH, 2, match bonus
- MISMATCH, 1, mismatch penalty
- GAP, 1, gap penalty (up/left)
- clk  in  1  clock; one clock domain
- reset  in  1  synchronous, active-high
- in_valid  in  1  input beat valid
- in_ready  out  1  block accepts beat this cycle
- letter1, letter2  in  SYM_W  symbols compared
- up_val, left_val, diagonal_val  in  SCORE_W  neighbour scores
- tileNum  in  TILE_W  tile id (sideband)
- offset  in  OFF_W  cell offset in tile (sideband)
- last  in  1  final cell of tile
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- val  out  SCORE_W  cell score
- arrow  out  2  00 none, 01 up, 10 left, 11 diag
- tileNumOut, offsetOut  out  TILE_W/OFF_W  sideband of this result
- best_valid  out  1  one-cycle pulse, tile best ready
- best_val  out  SCORE_W  max score of finished tile
- best_offset  out  OFF_W  offset of that max
- best_tile  out  TILE_W  tile of that max

## Operation
- Stage 1 (penalty): r_up = up_val>GAP ? up_val−GAP : 0; r_left likewise; r_diag = (letter1==letter2) ? min(diagonal_val+MATCH, 2^SCORE_W−1) : (diagonal_val>MISMATCH ? diagonal_val−MISMATCH : 0). Internal adds are SCORE_W+1 bits and saturate, never wrap.
- Stage 2 (select): all three zero → val 0, arrow 00. Otherwise val = max. Ties: diag beats up and left; left beats up. Arrow is the winner's code.
- Sideband (tileNum, offset, last) is registered alongside the data in each stage.
- Best tracker: updates only on output handshake (out_valid&&out_ready). Strict val>best_val replaces best_val/best_offset/best_tile, so the first occurrence wins ties. A handshake with last=1 folds in that beat, then loads best_* and pulses best_valid. The running tracker clears to 0 for the next tile.
- Reset: all valid bits 0, all outputs 0, tracker cleared. Beats in flight are discarded. Reset has priority over every other event.

## Timing
- Latency: beat accepted in cycle N appears on out_valid in cycle N+2 if there is no stall.
- Throughput: 1 beat/cycle with out_ready held high.
- Stage advances when its successor is empty or advancing: s2_adv = !s2_valid || out_ready; s1_adv = !s1_valid || s2_adv; in_ready = s1_adv. in_ready is combinational from out_ready and does not depend on in_valid.
- A full stall (out_ready=0 with both stages valid) drops in_ready. The pipeline holds 2 beats with no loss.
- While out_valid && !out_ready, val, arrow and sideband stay stable.
- best_* update and best_valid rise the cycle after the last-beat handshake. best_valid is high for exactly 1 cycle. best_* hold until the next tile completes.
- Back-to-back tiles: a last beat followed by the next tile's first beat in consecutive cycles updates correctly; the new tile starts from 0.

## Configuration
- SW_BEST_TRACK_EN defined: the best tracker is compiled in as described.
- Not defined: the tracker logic is removed. best_valid, best_val, best_offset and best_tile are tied to 0, `last` is ignored, and the datapath and handshake are unchanged.

## Test plan
- Defaults, letters equal, diagonal_val=5, up=3, left=4 → val=7, arrow=11, 2 cycles after accept.
- Letters differ, diag=1, up=1, left=0 → val=0, arrow=00. Then up=6, left=6, diag=0 → val=5, arrow=10 (left wins tie).
- Letters equal, diagonal_val=254, SCORE_W=8 → val=255 (saturated), arrow=11.
- Stream 6 beats with out_ready low in cycles 2–5: in_ready drops after 2 beats buffered, all 6 results emerge in order, and held outputs do not change.
- SW_BEST_TRACK_EN: tile 3, scores 4,9,9,2 at offsets 0–3, last on offset 3 → best_valid one pulse, best_val=9, best_offset=1, best_tile=3. Next tile max 1 → best_val=1.
- Assert reset with 2 beats in flight → next cycle out_valid=0, all outputs 0, in_ready=1. No stale result appears after reset.
